// File: rtl/legv8_pkg.sv
// rtl/legv8_pkg.sv - shared LEGv8 constants: mul/div op encodings, XZR index, default widths
package legv8_pkg;
    localparam int DEF_WIDTH      = 64;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int XZR_IDX        = 31;

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_SMULH = 3'b001;
    localparam logic [2:0] OP_UMULH = 3'b010;
    localparam logic [2:0] OP_SDIV  = 3'b100;
    localparam logic [2:0] OP_UDIV  = 3'b101;

    function automatic logic op_is_legal(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_SMULH) || (op == OP_UMULH) ||
               (op == OP_SDIV) || (op == OP_UDIV);
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return (op == OP_SDIV) || (op == OP_UDIV);
    endfunction

    function automatic logic op_is_signed(input logic [2:0] op);
        return (op == OP_SMULH) || (op == OP_SDIV);
    endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/response bundle between issue logic and the mul/div unit
interface mul_div_unit_if
    import legv8_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
);
    logic                  start;
    logic [2:0]            op;
    logic [WIDTH-1:0]      operand_a;
    logic [WIDTH-1:0]      operand_b;
    logic [REG_ADDR_W-1:0] dest_reg;
    logic                  flush;
    logic                  ready;
    logic                  done;
    logic [WIDTH-1:0]      result;
    logic [REG_ADDR_W-1:0] result_reg;
    logic                  reg_write;

    modport master (
        output start, op, operand_a, operand_b, dest_reg, flush,
        input  ready, done, result, result_reg, reg_write
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_reg, flush,
        output ready, done, result, result_reg, reg_write
    );
endinterface

// File: rtl/md_twos_negate.sv
// rtl/md_twos_negate.sv - conditional two's-complement negate
module md_twos_negate #(
    parameter int WIDTH = 64
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_value,
    output logic [WIDTH-1:0] o_value
);
    assign o_value = i_neg ? (~i_value + WIDTH'(1)) : i_value;
endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative one-bit-per-cycle MUL/SMULH/UMULH/SDIV/UDIV unit
module mul_div_unit
    import legv8_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    mul_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                r_state, w_next;
    logic [2:0]            r_op;
    logic [REG_ADDR_W-1:0] r_dest, r_result_reg;
    logic [CW-1:0]         r_iter;
    logic                  r_neg, r_b_zero;
    logic [WIDTH-1:0]      r_hi, r_lo, r_a, r_result;

    logic                  w_accept, w_signed_in, w_div_in;
    logic [WIDTH-1:0]      w_abs_a, w_abs_b;
    logic [WIDTH:0]        w_mul_sum, w_div_sh;
    logic                  w_div_ge;
    logic [WIDTH-1:0]      w_div_diff, w_div_rem, w_result;
    logic [2*WIDTH-1:0]    w_fix_in, w_fix_out;

    assign w_accept    = (r_state == IDLE) && bus.start && !bus.flush;
    assign w_signed_in = op_is_signed(bus.op);
    assign w_div_in    = op_is_div(bus.op);

    md_twos_negate #(.WIDTH(WIDTH)) u_abs_a (
        .i_neg(w_signed_in & bus.operand_a[WIDTH-1]), .i_value(bus.operand_a), .o_value(w_abs_a));
    md_twos_negate #(.WIDTH(WIDTH)) u_abs_b (
        .i_neg(w_signed_in & bus.operand_b[WIDTH-1]), .i_value(bus.operand_b), .o_value(w_abs_b));

    // Multiply: {r_hi,r_lo} shifts right with r_lo holding the unconsumed multiplier bits.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ge   = w_div_sh >= {1'b0, r_a};
    assign w_div_diff = w_div_sh[WIDTH-1:0] - r_a;
    assign w_div_rem  = w_div_ge ? w_div_diff : w_div_sh[WIDTH-1:0];

    assign w_fix_in = op_is_div(r_op) ? {{WIDTH{1'b0}}, r_lo} : {r_hi, r_lo};

    md_twos_negate #(.WIDTH(2*WIDTH)) u_fix (
        .i_neg(r_neg), .i_value(w_fix_in), .o_value(w_fix_out));

    always_comb begin
        w_result = '0;
        case (r_op)
            OP_MUL:            w_result = w_fix_out[WIDTH-1:0];
            OP_SMULH, OP_UMULH: w_result = w_fix_out[2*WIDTH-1:WIDTH];
            OP_SDIV, OP_UDIV:  w_result = r_b_zero ? '0 : w_fix_out[WIDTH-1:0];
            default:           w_result = '0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (bus.flush) w_next = IDLE;
                     else if (r_iter == CW'(WIDTH)) w_next = FIX;
            FIX:     w_next = bus.flush ? IDLE : DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op         <= '0;
            r_dest       <= '0;
            r_result_reg <= '0;
            r_iter       <= '0;
            r_neg        <= 1'b0;
            r_b_zero     <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_a          <= '0;
            r_result     <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op     <= bus.op;
                    r_dest   <= bus.dest_reg;
                    r_iter   <= '0;
                    r_neg    <= w_signed_in & (bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1]);
                    r_b_zero <= (bus.operand_b == '0);
                    r_hi     <= '0;
                    r_lo     <= w_div_in ? w_abs_a : w_abs_b;
                    r_a      <= w_div_in ? w_abs_b : w_abs_a;
                end
                CALC: if (r_iter != CW'(WIDTH)) begin
                    r_iter <= r_iter + CW'(1);
                    if (op_is_div(r_op)) begin
                        r_hi <= w_div_rem;
                        r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
                    end else begin
                        r_hi <= w_mul_sum[WIDTH:1];
                        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
                    end
                end
                FIX: if (!bus.flush) begin
                    r_result     <= w_result;
                    r_result_reg <= r_dest;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready      = (r_state == IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.result     = r_result;
    assign bus.result_reg = r_result_reg;
    assign bus.reg_write  = (r_state == DONE) && op_is_legal(r_op) &&
                            (r_result_reg != REG_ADDR_W'(XZR_IDX));
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  dest;
        logic [63:0] exp;
        logic        exp_rw;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] d, input int poke_edge, input int flush_edge,
                          output int lat, output logic got);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.operand_a = a; bus.operand_b = b; bus.dest_reg = d;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            if (lat + 1 == poke_edge) begin
                chk("busy_not_ready", {63'd0, bus.ready}, 64'd0);
                bus.start = 1'b1; bus.op = 3'b000;
                bus.operand_a = '1; bus.operand_b = '1; bus.dest_reg = 5'd0;
            end
            if (lat + 1 == flush_edge) bus.flush = 1'b1;
            @(posedge clk); #1;
            lat++;
            if (lat == poke_edge) bus.start = 1'b0;
            if (lat == flush_edge) begin
                bus.flush = 1'b0;
                chk("flush_to_idle", {63'd0, bus.ready}, 64'd1);
            end
            if (bus.done) got = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        logic got;
        int   seen;

        bus.start = 1'b0; bus.op = 3'b000; bus.operand_a = '0; bus.operand_b = '0;
        bus.dest_reg = '0; bus.flush = 1'b0;

        vecs[0]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'd1, 1'b1};
        vecs[1]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[2]  = '{3'b000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd2, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1};
        vecs[3]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
        vecs[4]  = '{3'b101, 64'd7, 64'd0, 5'd4, 64'd0, 1'b1};
        vecs[5]  = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6,
                     64'h8000_0000_0000_0000, 1'b1};
        vecs[6]  = '{3'b000, 64'd6, 64'd7, 5'd31, 64'd42, 1'b0};
        vecs[7]  = '{3'b011, 64'd5, 64'd3, 5'd8, 64'd0, 1'b0};
        vecs[8]  = '{3'b111, 64'd9, 64'd9, 5'd31, 64'd0, 1'b0};
        vecs[9]  = '{3'b101, 64'd100, 64'd7, 5'd9, 64'd14, 1'b1};
        vecs[10] = '{3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1};
        vecs[11] = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd11, 64'd0, 1'b1};
        vecs[12] = '{3'b010, 64'h8000_0000_0000_0000, 64'd4, 5'd12, 64'd2, 1'b1};
        vecs[13] = '{3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd13,
                     64'h4000_0000_0000_0000, 1'b1};
        vecs[14] = '{3'b100, 64'h8000_0000_0000_0000, 64'd2, 5'd14,
                     64'hC000_0000_0000_0000, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, bus.ready}, 64'd1);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_result_reg", {59'd0, bus.result_reg}, 64'd0);
        chk("rst_reg_write", {63'd0, bus.reg_write}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, 0, 0, lat, got);
            chk("vec_done_seen", {63'd0, got}, 64'd1);
            chk("vec_latency", 64'(lat), 64'd66);
            chk("vec_result", bus.result, vecs[i].exp);
            chk("vec_result_reg", {59'd0, bus.result_reg}, {59'd0, vecs[i].dest});
            chk("vec_reg_write", {63'd0, bus.reg_write}, {63'd0, vecs[i].exp_rw});
            @(posedge clk); #1;
            chk("vec_done_pulse", {63'd0, bus.done}, 64'd0);
            chk("vec_ready_back", {63'd0, bus.ready}, 64'd1);
            chk("vec_result_hold", bus.result, vecs[i].exp);
        end

        // second start while busy must not disturb the in-flight op
        run_op(3'b101, 64'd1000, 64'd3, 5'd7, 10, 0, lat, got);
        chk("poke_done_seen", {63'd0, got}, 64'd1);
        chk("poke_latency", 64'(lat), 64'd66);
        chk("poke_result", bus.result, 64'd333);
        chk("poke_result_reg", {59'd0, bus.result_reg}, 64'd7);
        @(posedge clk); #1;

        // flush mid-CALC abandons the op and leaves the previous result in place
        run_op(3'b101, 64'd50, 64'd5, 5'd15, 0, 30, lat, got);
        chk("flush_calc_no_done", {63'd0, got}, 64'd0);
        chk("flush_calc_result_held", bus.result, 64'd333);
        chk("flush_calc_reg_held", {59'd0, bus.result_reg}, 64'd7);

        // flush sampled on the FIX edge
        run_op(3'b000, 64'd3, 64'd4, 5'd16, 0, 66, lat, got);
        chk("flush_fix_no_done", {63'd0, got}, 64'd0);
        chk("flush_fix_result_held", bus.result, 64'd333);

        // flush and start together in IDLE: start dropped
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'b000;
        bus.operand_a = 64'd2; bus.operand_b = 64'd2; bus.dest_reg = 5'd17;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start_ready", {63'd0, bus.ready}, 64'd1);
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus.done || !bus.ready) seen++;
        end
        chk("flush_start_dropped", 64'(seen), 64'd0);

        // async reset in the middle of a UDIV
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'b101; bus.operand_a = 64'd99; bus.operand_b = 64'd9;
        bus.dest_reg = 5'd18;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_ready", {63'd0, bus.ready}, 64'd1);
        chk("midrst_done", {63'd0, bus.done}, 64'd0);
        chk("midrst_result", bus.result, 64'd0);
        chk("midrst_result_reg", {59'd0, bus.result_reg}, 64'd0);
        chk("midrst_reg_write", {63'd0, bus.reg_write}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        chk("midrst_no_done", 64'(seen), 64'd0);

        run_op(3'b101, 64'd1000, 64'd3, 5'd20, 0, 0, lat, got);
        chk("post_rst_done_seen", {63'd0, got}, 64'd1);
        chk("post_rst_latency", 64'(lat), 64'd66);
        chk("post_rst_result", bus.result, 64'd333);
        chk("post_rst_result_reg", {59'd0, bus.result_reg}, 64'd20);
        chk("post_rst_reg_write", {63'd0, bus.reg_write}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
